rtc_bus_scheduler: RTL and testbench
====================================

RTC_BUS_SCHEDULER -- requirements
Module: rtc_bus_scheduler

Interface
REQ-001 Parameter T_PH, default 4, SHALL set the cycles per bus phase, legal range 2..15.
REQ-002 reloj  in  1  system clock; all state SHALL change on its rising edge only.
REQ-003 resetM  in  1  reset, synchronous and active-high.
REQ-004 frame_tick  in  1  one-cycle pulse at start of vertical blanking; requests a read sweep.
REQ-005 wr_req  in  1  user write request, held high until wr_ack.
REQ-006 wr_addr  in  8  RTC register address for the write, sampled with wr_req.
REQ-007 wr_data  in  8  write data, sampled with wr_req.
REQ-008 wr_ack  out  1  one-cycle pulse in the GAP cycle ending a write access.
REQ-009 bus_din  in  8  DIR_DATO value as seen from the RTC.
REQ-010 bus_dout  out  8  value to drive onto DIR_DATO.
REQ-011 bus_oe  out  1  DIR_DATO driver enable; the top level SHALL tristate the bus when low.
REQ-012 ad_n, rd_n, wr_n, cs_n  out  1 each  active-low RTC strobes.
REQ-013 READ  out  1  one-cycle pulse: rd_data/POSICION valid for graphics.
REQ-014 POSICION  out  4  sweep index 0..8 of the value in rd_data.
REQ-015 rd_data  out  8  last register value read.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 overrun  out  1  sticky; set when frame_tick arrives while a sweep is unfinished.

Function
REQ-018 Sweep table SHALL be fixed, index 0..8 -> address 0x21,0x22,0x23,0x24,0x25,0x26,0x41,0x42,0x43 (sec, min, hr, day, month, year, crono sec, min, hr).
REQ-019 FSM states SHALL be IDLE, ADDR, DATA_RD, DATA_WR, GAP.
REQ-020 In ADDR, for T_PH cycles: cs_n=0, ad_n=0, bus_oe=1, bus_dout=target address.
REQ-021 In DATA_RD, for T_PH cycles: cs_n=0, rd_n=0, bus_oe=0. bus_din SHALL be sampled on the last DATA_RD cycle.
REQ-022 In DATA_WR, for T_PH cycles: cs_n=0, wr_n=0, bus_oe=1, bus_dout=latched wr_data.
REQ-023 GAP SHALL last 1 cycle with all strobes high and bus_oe=0, then go to IDLE.
REQ-024 Each access SHALL take exactly 2*T_PH+1 cycles, ADDR through GAP inclusive.
REQ-025 Read data:
  - READ SHALL pulse in the GAP cycle of every read access.
  - rd_data and POSICION SHALL update in that same cycle and hold until the next READ.
REQ-026 frame_tick in IDLE with no sweep active SHALL start a sweep at index 0.
  - An access SHALL begin (ADDR) on the next cycle.
REQ-027 While a sweep is active, IDLE SHALL launch the next index; the sweep SHALL end after index 8's GAP.
REQ-028 Arbitration in IDLE:
  - A pending wr_req SHALL win over the sweep.
  - The sweep SHALL resume at the same index after the write.
  - Accesses SHALL never be preempted mid-access.
REQ-029 wr_addr/wr_data SHALL be latched on the IDLE->ADDR transition for a write; later input changes are ignored.
REQ-030 frame_tick while a sweep is active SHALL be dropped, set overrun, and leave the index unchanged.
REQ-031 frame_tick and wr_req in the same IDLE cycle: the write SHALL go first; the sweep SHALL start after its GAP.
REQ-032 bus_oe SHALL never be high in the cycle a DATA_RD begins or in GAP (bus turnaround).
REQ-033 Index counter arithmetic: 4-bit, increment on read GAP only, reset to 0 at sweep end.

Reset
REQ-034 resetM high at a clock edge SHALL force all of the following, mid-access included, with no partial strobe cycle:
  - state IDLE, sweep inactive, index 0;
  - cs_n=ad_n=rd_n=wr_n=1, bus_oe=0, bus_dout=0x00;
  - READ=0, wr_ack=0, rd_data=0x00, POSICION=0, busy=0, overrun=0.
REQ-035 Any pending write SHALL be discarded by reset; wr_req still high after reset SHALL be served afresh.

Verification
REQ-036 T_PH=4, single frame_tick, bus_din = 0x10+index -> 9 READ pulses 9 cycles apart, POSICION 0..8, rd_data 0x10..0x18, busy low after 81 cycles.
REQ-037 wr_req (addr 0x22, data 0x59) raised during index-3 DATA_RD -> index 3 completes; write access drives 0x22 then 0x59 with wr_n low 4 cycles; wr_ack pulses; index 4 follows.
REQ-038 frame_tick and wr_req in the same cycle -> write first, wr_ack, then READ with POSICION=0 at +18 cycles.
REQ-039 Second frame_tick at sweep index 5 -> overrun=1, sweep ends at index 8, no restart.
REQ-040 resetM pulsed in DATA_RD of index 2 -> next cycle all outputs at reset values; next frame_tick restarts at index 0.
REQ-041 Checker on every cycle: bus_oe=1 only in ADDR/DATA_WR, and at most one of rd_n/wr_n/ad_n low.

Source files
------------

// File: rtl/rtc_bus_scheduler.sv
// Multiplexed-bus access scheduler for the RTC: sweeps nine time registers once
// per frame and interleaves user writes, each access being ADDR, DATA and GAP phases.
module rtc_bus_scheduler #(
    parameter int T_PH = 4
) (
    input  logic       reloj,
    input  logic       resetM,
    input  logic       frame_tick,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    input  logic [7:0] bus_din,
    output logic [7:0] bus_dout,
    output logic       bus_oe,
    output logic       ad_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       cs_n,
    output logic       READ,
    output logic [3:0] POSICION,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic [2:0] {IDLE, ADDR, DATA_RD, DATA_WR, GAP} state_t;

    localparam logic [3:0] PH_LAST = 4'(T_PH - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] pos_q, pos_d;
    logic       sweep_q, sweep_d;
    logic       op_wr_q, op_wr_d;
    logic       ovr_q, ovr_d;
    logic [7:0] rdat_q, rdat_d;
    logic [7:0] tgt_q, tgt_d;
    logic [7:0] wdat_q, wdat_d;
    logic       phase_end;
    logic       rd_gap;
    logic       sweep_end;
    logic       wr_go;

    function automatic logic [7:0] sweep_addr(input logic [3:0] i);
        case (i)
            4'd0:    sweep_addr = 8'h21;
            4'd1:    sweep_addr = 8'h22;
            4'd2:    sweep_addr = 8'h23;
            4'd3:    sweep_addr = 8'h24;
            4'd4:    sweep_addr = 8'h25;
            4'd5:    sweep_addr = 8'h26;
            4'd6:    sweep_addr = 8'h41;
            4'd7:    sweep_addr = 8'h42;
            4'd8:    sweep_addr = 8'h43;
            default: sweep_addr = 8'h00;
        endcase
    endfunction

    assign phase_end = (cnt_q == PH_LAST);
    assign rd_gap    = (state_q == GAP) && !op_wr_q;
    assign sweep_end = rd_gap && (idx_q == 4'd8);
    // The write being acked in its own GAP still has wr_req high; it must not relaunch.
    assign wr_go     = wr_req && !((state_q == GAP) && op_wr_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        op_wr_d = op_wr_q;
        rdat_d  = rdat_q;
        tgt_d   = tgt_q;
        wdat_d  = wdat_q;
        ovr_d   = ovr_q | (frame_tick & sweep_q);
        sweep_d = sweep_q ? !sweep_end : frame_tick;

        if (sweep_end) begin
            idx_d = 4'd0;
        end else if (rd_gap) begin
            idx_d = idx_q + 4'd1;
        end

        case (state_q)
            IDLE, GAP: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
                if (wr_go) begin
                    state_d = ADDR;
                    op_wr_d = 1'b1;
                    tgt_d   = wr_addr;
                    wdat_d  = wr_data;
                end else if (sweep_d) begin
                    state_d = ADDR;
                    op_wr_d = 1'b0;
                    tgt_d   = sweep_addr(idx_d);
                end
            end
            ADDR: begin
                if (phase_end) begin
                    cnt_d   = 4'd0;
                    state_d = op_wr_q ? DATA_WR : DATA_RD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DATA_RD: begin
                if (phase_end) begin
                    cnt_d   = 4'd0;
                    state_d = GAP;
                    rdat_d  = bus_din;
                    pos_d   = idx_q;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DATA_WR: begin
                if (phase_end) begin
                    cnt_d   = 4'd0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge reloj) begin
        if (resetM) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= 4'd0;
            pos_q   <= 4'd0;
            sweep_q <= 1'b0;
            op_wr_q <= 1'b0;
            ovr_q   <= 1'b0;
            rdat_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            sweep_q <= sweep_d;
            op_wr_q <= op_wr_d;
            ovr_q   <= ovr_d;
            rdat_q  <= rdat_d;
        end
    end

    // Address/data latches are only observed in ADDR/DATA_WR, so they carry no reset.
    always_ff @(posedge reloj) begin
        tgt_q  <= tgt_d;
        wdat_q <= wdat_d;
    end

    assign cs_n     = !((state_q == ADDR) || (state_q == DATA_RD) || (state_q == DATA_WR));
    assign ad_n     = (state_q != ADDR);
    assign rd_n     = (state_q != DATA_RD);
    assign wr_n     = (state_q != DATA_WR);
    assign bus_oe   = (state_q == ADDR) || (state_q == DATA_WR);
    assign bus_dout = (state_q == ADDR)    ? tgt_q  :
                      (state_q == DATA_WR) ? wdat_q : 8'h00;
    assign READ     = (state_q == GAP) && !op_wr_q;
    assign wr_ack   = (state_q == GAP) && op_wr_q;
    assign busy     = (state_q != IDLE);
    assign overrun  = ovr_q;
    assign rd_data  = rdat_q;
    assign POSICION = pos_q;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Directed bench for rtc_bus_scheduler: sweep timing, write arbitration, overrun and reset.
module tb_rtc_bus_scheduler;

    logic       reloj = 1'b0;
    logic       resetM = 1'b1;
    logic       frame_tick = 1'b0;
    logic       wr_req = 1'b0;
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ack;
    logic [7:0] bus_din;
    logic [7:0] bus_dout;
    logic       bus_oe, ad_n, rd_n, wr_n, cs_n, READ, busy, overrun;
    logic [3:0] POSICION;
    logic [7:0] rd_data;

    int pass_cnt = 0;
    int total_cnt = 0;
    int k = 0;
    int viol = 0;
    int wr_low = 0;
    int wsnap = 0;
    logic [7:0] rtc_addr = 8'h00;

    rtc_bus_scheduler #(.T_PH(4)) dut (
        .reloj(reloj), .resetM(resetM), .frame_tick(frame_tick),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .bus_din(bus_din), .bus_dout(bus_dout), .bus_oe(bus_oe),
        .ad_n(ad_n), .rd_n(rd_n), .wr_n(wr_n), .cs_n(cs_n),
        .READ(READ), .POSICION(POSICION), .rd_data(rd_data),
        .busy(busy), .overrun(overrun)
    );

    always #5 reloj = ~reloj;

    // RTC model: latches the address phase and returns 0x10+sweep index.
    always @(posedge reloj) if (!ad_n) rtc_addr <= bus_dout;

    always_comb begin
        case (rtc_addr)
            8'h21: bus_din = 8'h10;
            8'h22: bus_din = 8'h11;
            8'h23: bus_din = 8'h12;
            8'h24: bus_din = 8'h13;
            8'h25: bus_din = 8'h14;
            8'h26: bus_din = 8'h15;
            8'h41: bus_din = 8'h16;
            8'h42: bus_din = 8'h17;
            8'h43: bus_din = 8'h18;
            default: bus_din = 8'hEE;
        endcase
    end

    always @(negedge reloj) begin
        if (bus_oe && ad_n && wr_n) viol <= viol + 1;
        if ($countones({~ad_n, ~rd_n, ~wr_n}) > 1) viol <= viol + 1;
        if (!wr_n) wr_low <= wr_low + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic adv_to(input int target);
        while (k < target) begin
            @(negedge reloj);
            k++;
        end
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        k = 0;
        adv_to(1);
        frame_tick = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_strobes"}, 32'({cs_n, ad_n, rd_n, wr_n, bus_oe, READ, wr_ack, busy, overrun}),
            32'b1_1110_0000);
        chk({tag, "_dout"}, 32'(bus_dout), 32'h00);
        chk({tag, "_rddata"}, 32'(rd_data), 32'h00);
        chk({tag, "_pos"}, 32'(POSICION), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge reloj);
        chk_reset("rst0");
        resetM = 1'b0;
        repeat (2) @(negedge reloj);

        // Full sweep: READ every 9 cycles, POSICION 0..8, data 0x10..0x18
        pulse_tick();
        for (int c = 1; c <= 82; c++) begin
            adv_to(c);
            chk("sw_read", 32'(READ), 32'((c % 9 == 0) && (c <= 81)));
            if (c % 9 == 0) begin
                chk("sw_pos", 32'(POSICION), 32'(c / 9 - 1));
                chk("sw_data", 32'(rd_data), 32'(8'h10 + c / 9 - 1));
            end
            if (c == 1) chk("sw_addr0", 32'({ad_n, cs_n, bus_oe, bus_dout}), 32'h0_1_21);
            if (c == 5) chk("sw_rdph", 32'({rd_n, bus_oe, cs_n}), 32'b000);
            if (c == 81) chk("sw_busy81", 32'(busy), 32'd1);
            if (c == 82) chk("sw_busy82", 32'(busy), 32'd0);
        end

        // Write raised during index-3 DATA_RD
        adv_to(84);
        pulse_tick();
        adv_to(33);
        wr_req = 1'b1; wr_addr = 8'h22; wr_data = 8'h59;
        adv_to(36);
        chk("w3_read", 32'({READ, POSICION, rd_data}), 32'h1_3_13);
        wsnap = wr_low;
        adv_to(37);
        chk("w3_addr", 32'({ad_n, bus_oe, bus_dout}), 32'b01_0010_0010);
        wr_addr = 8'h99; wr_data = 8'h00;
        adv_to(41);
        chk("w3_data", 32'({wr_n, bus_oe, bus_dout}), 32'b01_0101_1001);
        adv_to(45);
        chk("w3_ack", 32'({wr_ack, READ}), 32'b10);
        wr_req = 1'b0;
        adv_to(46);
        chk("w3_next", 32'({wr_ack, ad_n, bus_dout}), 32'h0_25);
        chk("w3_wrlow", 32'(wr_low - wsnap), 32'd4);
        adv_to(54);
        chk("w3_idx4", 32'({READ, POSICION, rd_data}), 32'h1_4_14);
        adv_to(90);
        chk("w3_idx8", 32'({READ, POSICION}), 32'h1_8);
        adv_to(91);
        chk("w3_idle", 32'(busy), 32'd0);

        // frame_tick and wr_req together: write first, sweep after
        adv_to(93);
        frame_tick = 1'b1; wr_req = 1'b1; wr_addr = 8'h41; wr_data = 8'hA5;
        k = 0;
        adv_to(1);
        frame_tick = 1'b0;
        chk("tw_addr", 32'({ad_n, bus_dout}), 32'h0_41);
        adv_to(5);
        chk("tw_data", 32'({wr_n, bus_dout}), 32'h0_A5);
        adv_to(9);
        chk("tw_ack", 32'({wr_ack, READ}), 32'b10);
        wr_req = 1'b0;
        adv_to(10);
        chk("tw_rdaddr", 32'({ad_n, bus_dout}), 32'h0_21);
        adv_to(18);
        chk("tw_read0", 32'({READ, POSICION, rd_data}), 32'h1_0_10);
        adv_to(91);
        chk("tw_idle", 32'(busy), 32'd0);

        // Second frame_tick at index 5: overrun, no restart
        adv_to(93);
        pulse_tick();
        adv_to(48);
        chk("ov_before", 32'(overrun), 32'd0);
        frame_tick = 1'b1;
        adv_to(49);
        frame_tick = 1'b0;
        chk("ov_set", 32'(overrun), 32'd1);
        adv_to(54);
        chk("ov_idx5", 32'({READ, POSICION}), 32'h1_5);
        adv_to(81);
        chk("ov_idx8", 32'({READ, POSICION}), 32'h1_8);
        adv_to(90);
        chk("ov_norestart", 32'({busy, overrun}), 32'b01);

        // Reset mid-access in DATA_RD of index 2
        resetM = 1'b1;
        adv_to(92);
        resetM = 1'b0;
        chk_reset("rst1");
        adv_to(94);
        pulse_tick();
        adv_to(18);
        chk("rs_idx1", 32'({READ, POSICION, rd_data}), 32'h1_1_11);
        adv_to(24);
        chk("rs_inrd", 32'({rd_n, cs_n}), 32'b00);
        resetM = 1'b1;
        adv_to(25);
        resetM = 1'b0;
        chk_reset("rst2");
        adv_to(27);
        chk("rs_stay", 32'(busy), 32'd0);
        pulse_tick();
        adv_to(9);
        chk("rs_restart", 32'({READ, POSICION, rd_data}), 32'h1_0_10);
        adv_to(82);

        // wr_req held across reset is served afresh
        wr_req = 1'b1; wr_addr = 8'h23; wr_data = 8'h07;
        k = 0;
        adv_to(2);
        chk("rw_addr", 32'({ad_n, bus_dout}), 32'h0_23);
        resetM = 1'b1;
        adv_to(3);
        resetM = 1'b0;
        chk("rw_rst", 32'({busy, ad_n}), 32'b01);
        adv_to(4);
        chk("rw_again", 32'({ad_n, bus_dout}), 32'h0_23);
        adv_to(8);
        chk("rw_data", 32'({wr_n, bus_dout}), 32'h0_07);
        adv_to(12);
        chk("rw_ack", 32'(wr_ack), 32'd1);
        wr_req = 1'b0;
        adv_to(13);
        chk("rw_idle", 32'(busy), 32'd0);

        chk("bus_rules", 32'(viol), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
